// File: rtl/forward_history_if.sv
// Bundle of read, write-back and corrected-bucket signals for the
// forward history unit; master drives reads/write-backs, slave corrects.
interface forward_history_if #(
    parameter int DATA_WIDTH         = 4,
    parameter int KEY_WIDTH          = 2,
    parameter int NUMBER_OF_TABLES   = 4,
    parameter int BUCKET_SIZE        = 1,
    parameter int MAX_HASH_ADR_WIDTH = 2,
    parameter int FORWARD_DEPTH      = 2
) ();
    localparam int NT    = NUMBER_OF_TABLES;
    localparam int AW    = MAX_HASH_ADR_WIDTH;
    localparam int BS    = BUCKET_SIZE;
    localparam int CW    = (KEY_WIDTH + DATA_WIDTH) * BUCKET_SIZE;
    localparam int AGE_W = $clog2(FORWARD_DEPTH + 1);

    logic [NT-1:0][AW-1:0]    new_hash_adr_i;
    logic [NT-1:0][CW-1:0]    new_content_i;
    logic [NT-1:0][BS-1:0]    new_valid_i;
    logic [NT-1:0][AW-1:0]    forward_hash_adr_i;
    logic [NT-1:0][CW-1:0]    forward_content_i;
    logic [NT-1:0][BS-1:0]    forward_valid_i;
    logic [NT-1:0]            forward_updated_mem_i;
    logic [NT-1:0][CW-1:0]    correct_content_o;
    logic [NT-1:0][BS-1:0]    correct_is_valid_o;
    logic [NT-1:0]            hit_o;
    logic [NT-1:0][AGE_W-1:0] hit_age_o;

    modport master (
        output new_hash_adr_i, new_content_i, new_valid_i,
        output forward_hash_adr_i, forward_content_i, forward_valid_i,
        output forward_updated_mem_i,
        input  correct_content_o, correct_is_valid_o, hit_o, hit_age_o
    );

    modport slave (
        input  new_hash_adr_i, new_content_i, new_valid_i,
        input  forward_hash_adr_i, forward_content_i, forward_valid_i,
        input  forward_updated_mem_i,
        output correct_content_o, correct_is_valid_o, hit_o, hit_age_o
    );
endinterface

// File: rtl/forward_history_unit.sv
// Per-table history of recent write-backs; patches stale bucket reads
// with the youngest live write to the same bucket address.
module forward_history_unit #(
    parameter int DATA_WIDTH         = 4,
    parameter int KEY_WIDTH          = 2,
    parameter int NUMBER_OF_TABLES   = 4,
    parameter int BUCKET_SIZE        = 1,
    parameter int MAX_HASH_ADR_WIDTH = 2,
    parameter int FORWARD_DEPTH      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush_i,
    forward_history_if.slave  bus
);
    localparam int NT    = NUMBER_OF_TABLES;
    localparam int D     = FORWARD_DEPTH;
    localparam int AW    = MAX_HASH_ADR_WIDTH;
    localparam int BS    = BUCKET_SIZE;
    localparam int CW    = (KEY_WIDTH + DATA_WIDTH) * BUCKET_SIZE;
    localparam int AGE_W = $clog2(FORWARD_DEPTH + 1);

    // index 0 holds age 1 (youngest)
    logic [NT-1:0][D-1:0][AW-1:0] h_adr;
    logic [NT-1:0][D-1:0][CW-1:0] h_content;
    logic [NT-1:0][D-1:0][BS-1:0] h_valid;
    logic [NT-1:0][D-1:0]         h_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_adr     <= '0;
            h_content <= '0;
            h_valid   <= '0;
            h_live    <= '0;
        end else if (clk_en) begin
            for (int t = 0; t < NT; t++) begin
                for (int k = D - 1; k > 0; k--) begin
                    h_adr[t][k]     <= h_adr[t][k-1];
                    h_content[t][k] <= h_content[t][k-1];
                    h_valid[t][k]   <= h_valid[t][k-1];
                    h_live[t][k]    <= h_live[t][k-1] & ~flush_i;
                end
                // the in-flight write survives a flush
                h_adr[t][0]     <= bus.forward_hash_adr_i[t];
                h_content[t][0] <= bus.forward_content_i[t];
                h_valid[t][0]   <= bus.forward_valid_i[t];
                h_live[t][0]    <= bus.forward_updated_mem_i[t];
            end
        end else if (flush_i) begin
            h_live <= '0;
        end
    end

    always_comb begin
        bus.correct_content_o  = bus.new_content_i;
        bus.correct_is_valid_o = bus.new_valid_i;
        bus.hit_o              = '0;
        bus.hit_age_o          = '0;
        for (int t = 0; t < NT; t++) begin
            // oldest first so the youngest match is applied last
            for (int k = D - 1; k >= 0; k--) begin
                if (h_live[t][k] &&
                    h_adr[t][k] == bus.new_hash_adr_i[t]) begin
                    bus.correct_content_o[t]  = h_content[t][k];
                    bus.correct_is_valid_o[t] = h_valid[t][k];
                    bus.hit_o[t]              = 1'b1;
                    bus.hit_age_o[t]          = AGE_W'(k + 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_forward_history_unit.sv
// Directed bench for forward_history_unit at default parameters
// (4 tables, depth 2, 2-bit address, 6-bit content).
module tb_forward_history_unit;
    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    logic flush_i;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [3:0][5:0] nc;
    logic [3:0][0:0] nv;

    forward_history_if bus ();

    forward_history_unit dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd(input int t, input logic [1:0] a,
                       input logic [5:0] c, input logic u);
        bus.forward_hash_adr_i[t]    = a;
        bus.forward_content_i[t]     = c;
        bus.forward_valid_i[t]       = 1'b1;
        bus.forward_updated_mem_i[t] = u;
    endtask

    task automatic rd(input logic [1:0] a);
        for (int t = 0; t < 4; t++) bus.new_hash_adr_i[t] = a;
        #1;
    endtask

    task automatic hit0(input string tag, input logic [5:0] c,
                        input logic [1:0] age);
        chk({tag, "_hit"}, 32'(bus.hit_o[0]), 32'd1);
        chk({tag, "_age"}, 32'(bus.hit_age_o[0]), 32'(age));
        chk({tag, "_data"}, 32'(bus.correct_content_o[0]), 32'(c));
        chk({tag, "_vld"}, 32'(bus.correct_is_valid_o[0]), 32'd1);
    endtask

    task automatic miss0(input string tag);
        chk({tag, "_hit"}, 32'(bus.hit_o[0]), 32'd0);
        chk({tag, "_age"}, 32'(bus.hit_age_o[0]), 32'd0);
        chk({tag, "_data"}, 32'(bus.correct_content_o[0]), 32'h05);
        chk({tag, "_vld"}, 32'(bus.correct_is_valid_o[0]), 32'd0);
    endtask

    task automatic miss_all(input string tag);
        chk({tag, "_hit"}, 32'(bus.hit_o), 32'd0);
        chk({tag, "_age"}, 32'(bus.hit_age_o), 32'd0);
        chk({tag, "_data"}, 32'(bus.correct_content_o), 32'(nc));
        chk({tag, "_vld"}, 32'(bus.correct_is_valid_o), 32'(nv));
    endtask

    initial begin
        for (int t = 0; t < 4; t++) begin
            nc[t] = 6'(5 + t);
            nv[t] = 1'b0;
        end
        reset   = 1'b1;
        clk_en  = 1'b1;
        flush_i = 1'b0;
        bus.new_content_i = nc;
        bus.new_valid_i   = nv;
        for (int t = 0; t < 4; t++) fwd(t, 2'd0, 6'h00, 1'b0);
        rd(2'd0);
        tick();
        tick();
        reset = 1'b0;
        rd(2'd1);
        miss_all("reset");

        // single live write, forwarded one cycle later
        fwd(0, 2'd1, 6'h2A, 1'b1);
        rd(2'd1);
        miss0("same_cycle");
        tick();
        fwd(0, 2'd1, 6'h00, 1'b0);
        rd(2'd1);
        hit0("w1", 6'h2A, 2'd1);
        chk("w1_tbl1_hit", 32'(bus.hit_o[1]), 32'd0);
        tick();
        tick();
        rd(2'd1);
        miss0("w1_aged_out");

        // two writes to the same address: youngest wins, then ages out
        fwd(0, 2'd2, 6'h11, 1'b1);
        tick();
        fwd(0, 2'd2, 6'h22, 1'b1);
        tick();
        fwd(0, 2'd0, 6'h00, 1'b0);
        rd(2'd2);
        hit0("w2_age1", 6'h22, 2'd1);
        tick();
        rd(2'd2);
        hit0("w2_age2", 6'h22, 2'd2);
        tick();
        rd(2'd2);
        miss0("w2_gone");

        // write-back not committed to memory is never forwarded
        fwd(0, 2'd3, 6'h15, 1'b0);
        tick();
        rd(2'd3);
        miss0("not_updated");

        // history frozen while clk_en is low
        fwd(0, 2'd1, 6'h19, 1'b1);
        tick();
        fwd(0, 2'd0, 6'h00, 1'b0);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(2'd1);
            hit0($sformatf("hold%0d", i), 6'h19, 2'd1);
        end
        clk_en = 1'b1;
        tick();
        tick();

        // flush without advance kills the live entry
        fwd(0, 2'd0, 6'h07, 1'b1);
        tick();
        fwd(0, 2'd0, 6'h00, 1'b0);
        rd(2'd0);
        hit0("pre_flush", 6'h07, 2'd1);
        clk_en  = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        clk_en  = 1'b1;
        rd(2'd0);
        miss0("flush_hold");

        // flush with advance keeps only the in-flight write
        fwd(0, 2'd0, 6'h07, 1'b1);
        tick();
        fwd(0, 2'd0, 6'h3C, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        fwd(0, 2'd0, 6'h00, 1'b0);
        rd(2'd0);
        hit0("flush_adv1", 6'h3C, 2'd1);
        tick();
        rd(2'd0);
        hit0("flush_adv2", 6'h3C, 2'd2);

        // reset mid-stream with live entries in every table
        for (int t = 0; t < 4; t++) fwd(t, 2'd1, 6'(8'h30 + t), 1'b1);
        tick();
        rd(2'd1);
        chk("pre_rst_hits", 32'(bus.hit_o), 32'hF);
        chk("pre_rst_t3", 32'(bus.correct_content_o[3]), 32'h33);
        reset   = 1'b1;
        flush_i = 1'b0;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) fwd(t, 2'd0, 6'h00, 1'b0);
        rd(2'd1);
        miss_all("mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/forward_history_unit.md
FORWARD_HISTORY_UNIT -- requirements
Module: forward_history_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, data field width per slot.
REQ-002 SHALL have parameter KEY_WIDTH, default 2, key field width per slot.
REQ-003 SHALL have parameter NUMBER_OF_TABLES, default 4, number of independent table channels.
REQ-004 SHALL have parameter BUCKET_SIZE, default 1, slots per bucket.
REQ-005 SHALL have parameter MAX_HASH_ADR_WIDTH, default 2, bucket address width.
REQ-006 SHALL have parameter FORWARD_DEPTH, default 2 (legal 1..8), number of past write-backs tracked per table.
REQ-007 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have port clk_en  in  1  pipeline advance enable.
REQ-010 SHALL have port flush_i  in  1  clear all history entries.
REQ-011 SHALL have port new_hash_adr_i  in  [NUMBER_OF_TABLES] x MAX_HASH_ADR_WIDTH  address just read from memory.
REQ-012 SHALL have port new_content_i  in  [NUMBER_OF_TABLES] x (KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE  bucket content read from memory.
REQ-013 SHALL have port new_valid_i  in  [NUMBER_OF_TABLES] x BUCKET_SIZE  slot valid bits read from memory.
REQ-014 SHALL have ports forward_hash_adr_i, forward_content_i, forward_valid_i  in  same shapes as the new_* ports  write-back being committed this cycle.
REQ-015 SHALL have port forward_updated_mem_i  in  [NUMBER_OF_TABLES] x 1  write-back actually written to memory.
REQ-016 SHALL have ports correct_content_o, correct_is_valid_o  out  same shapes as new_content_i/new_valid_i  corrected bucket.
REQ-017 SHALL have port hit_o  out  [NUMBER_OF_TABLES] x 1  correction taken from history.
REQ-018 SHALL have port hit_age_o  out  [NUMBER_OF_TABLES] x $clog2(FORWARD_DEPTH+1)  age of the winning entry (1 = youngest), 0 on miss.

Function
REQ-019 SHALL keep, per table, a history of FORWARD_DEPTH entries {adr, content, valid, live}, entry 1 youngest.
REQ-020 SHALL, when clk_en=1, shift the history by one (entry k -> k+1, oldest discarded) and load entry 1 with the forward_*_i inputs, live = forward_updated_mem_i.
REQ-021 SHALL shift every clk_en cycle regardless of forward_updated_mem_i, so entry age equals pipeline distance in enabled cycles.
REQ-022 SHALL hold all history unchanged when clk_en=0.
REQ-023 SHALL declare entry k matching when live=1 and adr == new_hash_adr_i of the same table.
REQ-024 SHALL select the matching entry with the smallest age; correct_content_o/correct_is_valid_o = that entry's content/valid, hit_o=1, hit_age_o=age.
REQ-025 SHALL output new_content_i/new_valid_i, hit_o=0, hit_age_o=0 when no entry matches.
REQ-026 SHALL compute outputs combinationally from current history and new_* inputs (zero added latency; forwarding covers writes 1..FORWARD_DEPTH enabled cycles old).
REQ-027 SHALL, on flush_i=1, clear live in all entries; if clk_en=1 in the same cycle, entry 1 is loaded per REQ-020 after the clear (the in-flight write is retained).
REQ-028 SHALL keep tables fully independent; no cross-table comparison.
REQ-029 SHALL with FORWARD_DEPTH=1 behave identically to a single-register forwarder.

Reset
REQ-030 SHALL on reset=1 clear live, adr, content and valid in every entry of every table, overriding clk_en and flush_i.
REQ-031 SHALL, after reset and with new_* inputs stable, output correct_*_o = new_*_i, hit_o=0, hit_age_o=0 on all tables.

Verification
REQ-032 Bench SHALL cover: DEPTH=2; write adr 1 content 0x2A live, next enabled cycle read adr 1 -> content 0x2A, hit_o=1, hit_age_o=1.
REQ-033 Bench SHALL cover: writes adr 2 content 0x11 then adr 2 content 0x22 on consecutive enabled cycles, read adr 2 -> 0x22, hit_age_o=1; one enabled cycle later with no write -> 0x22, age 2; one more -> new_content_i, hit_o=0.
REQ-034 Bench SHALL cover: write adr 3 with forward_updated_mem_i=0 -> next read of adr 3 returns new_content_i, hit_o=0.
REQ-035 Bench SHALL cover: write adr 1 live, hold clk_en=0 for 5 cycles -> hit persists with hit_age_o=1 throughout.
REQ-036 Bench SHALL cover: history holding adr 0 live, assert flush_i with clk_en=1 and new write adr 0 content 0x3C -> next cycle hit, content 0x3C, age 1; older entry never selected.
REQ-037 Bench SHALL cover: reset asserted mid-stream with live entries -> next cycle all tables hit_o=0 and outputs equal new_*_i.
